// File: rtl/grid_cell_writer.sv
// Write-side engine for the 64x48 VGA grid RAM: expands cell, clipped-rect and
// clear commands into one RAM write per clock, scanned row-major.
module grid_cell_writer #(
    parameter int COLS = 64,
    parameter int ROWS = 48,
    parameter int AW   = 12,
    parameter int DW   = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCMD_VALID,
    output logic          oCMD_READY,
    input  logic [1:0]    iCMD_OP,
    input  logic [5:0]    iX,
    input  logic [5:0]    iY,
    input  logic [6:0]    iW,
    input  logic [5:0]    iH,
    input  logic [DW-1:0] iCOLOR,
    output logic [AW-1:0] oWRADDR,
    output logic [DW-1:0] oWRDATA,
    output logic          oWREN,
    output logic          oBUSY,
    output logic          oDONE
);
    localparam logic [6:0] COLS7 = 7'(COLS);
    localparam logic [6:0] ROWS7 = 7'(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [5:0]    x0_q, x0_d, cx_q, cx_d, cy_q, cy_d;
    logic [6:0]    xe_q, xe_d, ye_q, ye_d;
    logic [AW-1:0] wraddr_q, wraddr_d;
    logic [DW-1:0] wrdata_q, wrdata_d;
    logic          wren_q, wren_d, ready_q, ready_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [5:0] n_x, n_y, n_h;
    logic [6:0] n_w, x_sum, y_sum, n_xe, n_ye;
    logic       n_nop, n_empty;
    logic       last_col, last_row;
    logic [5:0] nx_cx, nx_cy;

    // Opcode normalisation and clipping of the incoming command.
    always_comb begin
        n_x   = iX;
        n_y   = iY;
        n_w   = iW;
        n_h   = iH;
        n_nop = 1'b0;
        case (iCMD_OP)
            2'd1: begin
                n_x = '0;
                n_y = '0;
                n_w = COLS7;
                n_h = 6'(ROWS);
            end
            2'd2: begin
                n_w = 7'd1;
                n_h = 6'd1;
            end
            2'd3:    n_nop = 1'b1;
            default: ;
        endcase
        x_sum   = {1'b0, n_x} + n_w;
        y_sum   = {1'b0, n_y} + {1'b0, n_h};
        n_xe    = (x_sum > COLS7) ? COLS7 : x_sum;
        n_ye    = (y_sum > ROWS7) ? ROWS7 : y_sum;
        n_empty = n_nop || (n_w == 7'd0) || (n_h == 6'd0) || ({1'b0, n_y} >= ROWS7);
    end

    always_comb begin
        last_col = ({1'b0, cx_q} == xe_q - 7'd1);
        last_row = ({1'b0, cy_q} == ye_q - 7'd1);
        nx_cx    = last_col ? x0_q : cx_q + 6'd1;
        nx_cy    = last_col ? cy_q + 6'd1 : cy_q;
    end

    // NOTE: every _d gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iCMD_VALID && ready_q) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (n_empty) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // The first write is presented on the accept edge itself.
                        state_d  = S_FILL;
                        wren_d   = 1'b1;
                        x0_d     = n_x;
                        cx_d     = n_x;
                        cy_d     = n_y;
                        xe_d     = n_xe;
                        ye_d     = n_ye;
                        wraddr_d = AW'({n_y, n_x});
                        wrdata_d = iCOLOR;
                    end
                end
            end
            S_FILL: begin
                if (last_col && last_row) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    wren_d   = 1'b1;
                    cx_d     = nx_cx;
                    cy_d     = nx_cy;
                    wraddr_d = AW'({nx_cy, nx_cx});
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the comb blocks above use blocking.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oCMD_READY = ready_q;
    assign oWRADDR    = wraddr_q;
    assign oWRDATA    = wrdata_q;
    assign oWREN      = wren_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule

// File: tb/tb_grid_cell_writer.sv
// Bench for grid_cell_writer: commands feed a reference model into expected queues,
// a negedge monitor logs RAM writes and DONE pulses, each test scores its own results.
module tb_grid_cell_writer;
    logic       iCLK = 1'b0;
    logic       iRST = 1'b1;
    logic       iCMD_VALID = 1'b0;
    logic [1:0] iCMD_OP = '0;
    logic [5:0] iX = '0, iY = '0, iH = '0;
    logic [6:0] iW = '0;
    logic [3:0] iCOLOR = '0;
    logic        oCMD_READY, oWREN, oBUSY, oDONE;
    logic [11:0] oWRADDR;
    logic [3:0]  oWRDATA;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [11:0] a;
        logic [3:0]  d;
    } wr_t;

    wr_t obs_wr[$];
    wr_t exp_wr[$];
    int  obs_done[$];
    int  exp_done[$];
    int  wr_base = 0;
    int  done_base = 0;

    grid_cell_writer #(.COLS(64), .ROWS(48), .AW(12), .DW(4)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCMD_VALID(iCMD_VALID), .oCMD_READY(oCMD_READY),
        .iCMD_OP(iCMD_OP), .iX(iX), .iY(iY), .iW(iW), .iH(iH), .iCOLOR(iCOLOR),
        .oWRADDR(oWRADDR), .oWRDATA(oWRDATA), .oWREN(oWREN), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Outputs seen at the negedge after edge k are logged with cycle k.
    always @(negedge iCLK) begin
        if (oWREN) obs_wr.push_back({32'(cyc), oWRADDR, oWRDATA});
        if (oDONE) obs_done.push_back(cyc);
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference model: writes logged at cyc t..t+N-1, DONE at t+N (t = accept edge).
    task automatic model_cmd(input int op, input int ix, input int iy, input int iw,
                             input int ih, input logic [3:0] color, input int t);
        int x, y, w, h, xe, ye, n;
        bit empty;
        x = ix; y = iy; w = iw; h = ih;
        empty = (op == 3);
        if (op == 1) begin x = 0; y = 0; w = 64; h = 48; end
        if (op == 2) begin w = 1; h = 1; end
        xe = (x + w < 64) ? x + w : 64;
        ye = (y + h < 48) ? y + h : 48;
        if (w == 0 || h == 0 || y >= 48) empty = 1'b1;
        n = 0;
        if (!empty)
            for (int r = y; r < ye; r++)
                for (int c = x; c < xe; c++) begin
                    exp_wr.push_back({32'(t + n), 12'(r * 64 + c), color});
                    n++;
                end
        exp_done.push_back(t + n);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge t.
    task automatic send(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                        input logic [6:0] w, input logic [5:0] h, input logic [3:0] color,
                        input bit hold, output int t);
        iCMD_VALID = 1'b1;
        iCMD_OP = op; iX = x; iY = y; iW = w; iH = h; iCOLOR = color;
        for (int i = 0; i < 100 && !oCMD_READY; i++) @(negedge iCLK);
        if (!oCMD_READY) begin
            total++; bad++;
            $display("FAIL accept_timeout ready=%b required 1", oCMD_READY);
        end
        t = cyc + 1;
        model_cmd(int'(op), int'(x), int'(y), int'(w), int'(h), color, t);
        @(negedge iCLK);
        if (!hold) iCMD_VALID = 1'b0;
    endtask

    task automatic settle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (obs_done.size() - done_base >= exp_done.size() && oCMD_READY) break;
            @(negedge iCLK);
        end
        repeat (4) @(negedge iCLK);
    endtask

    task automatic test_reset;
        total++;
        if ({oCMD_READY, oWREN, oWRADDR, oWRDATA, oBUSY, oDONE} !== {1'b1, 1'b0, 12'd0, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got rdy=%b wren=%b addr=%0d data=%0d busy=%b done=%b, required 1 0 0 0 0 0",
                     oCMD_READY, oWREN, oWRADDR, oWRDATA, oBUSY, oDONE);
        end
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        total++;
        if ({oCMD_READY, oWREN, oBUSY, oDONE} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_after_reset got rdy=%b wren=%b busy=%b done=%b, required 1 0 0 0",
                     oCMD_READY, oWREN, oBUSY, oDONE);
        end
    endtask

    task automatic test_single;
        int t;
        send(2'd2, 6'd5, 6'd3, 7'd0, 6'd0, 4'd9, 1'b0, t);
        total++;
        if ({oCMD_READY, oBUSY} !== 2'b01) begin
            bad++; $display("FAIL single_busy_fill got rdy=%b busy=%b, required 0 1", oCMD_READY, oBUSY);
        end
        @(negedge iCLK);
        total++;
        if ({oCMD_READY, oBUSY} !== 2'b01) begin
            bad++; $display("FAIL single_busy_done got rdy=%b busy=%b, required 0 1", oCMD_READY, oBUSY);
        end
        @(negedge iCLK);
        total++;
        if ({oCMD_READY, oBUSY} !== 2'b10) begin
            bad++; $display("FAIL single_ready_again got rdy=%b busy=%b, required 1 0", oCMD_READY, oBUSY);
        end
        settle(20);
        for (int i = 0; i < exp_wr.size(); i++) begin
            total++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL single_wr[%0d] got %h required cyc=%0d addr=%0d data=%0d", i,
                         (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : '0, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (obs_wr.size() - wr_base != exp_wr.size()) begin
            bad++; $display("FAIL single_wr_count got %0d required %0d", obs_wr.size() - wr_base, exp_wr.size());
        end
        for (int i = 0; i < exp_done.size(); i++) begin
            total++;
            if (done_base + i >= obs_done.size() || obs_done[done_base + i] != exp_done[i]) begin
                bad++; $display("FAIL single_done[%0d] required cyc=%0d", i, exp_done[i]);
            end
        end
        total++;
        if (obs_done.size() - done_base != exp_done.size()) begin
            bad++; $display("FAIL single_done_count got %0d required %0d", obs_done.size() - done_base, exp_done.size());
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    task automatic test_clipped_rect;
        int t;
        send(2'd0, 6'd62, 6'd46, 7'd4, 6'd4, 4'd7, 1'b0, t);
        settle(30);
        send(2'd0, 6'd10, 6'd20, 7'd3, 6'd2, 4'd12, 1'b0, t);
        settle(30);
        for (int i = 0; i < exp_wr.size(); i++) begin
            total++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL rect_wr[%0d] got %h required cyc=%0d addr=%0d data=%0d", i,
                         (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : '0, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (obs_wr.size() - wr_base != exp_wr.size()) begin
            bad++; $display("FAIL rect_wr_count got %0d required %0d", obs_wr.size() - wr_base, exp_wr.size());
        end
        for (int i = 0; i < exp_done.size(); i++) begin
            total++;
            if (done_base + i >= obs_done.size() || obs_done[done_base + i] != exp_done[i]) begin
                bad++; $display("FAIL rect_done[%0d] required cyc=%0d", i, exp_done[i]);
            end
        end
        total++;
        if (obs_done.size() - done_base != exp_done.size()) begin
            bad++; $display("FAIL rect_done_count got %0d required %0d", obs_done.size() - done_base, exp_done.size());
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    task automatic test_clear_all;
        int t;
        send(2'd1, 6'd7, 6'd9, 7'd3, 6'd2, 4'd0, 1'b0, t);
        settle(3200);
        for (int i = 0; i < exp_wr.size(); i++) begin
            total++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL clear_wr[%0d] got %h required cyc=%0d addr=%0d data=%0d", i,
                         (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : '0, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (obs_wr.size() - wr_base != 3072) begin
            bad++; $display("FAIL clear_wr_count got %0d required 3072", obs_wr.size() - wr_base);
        end
        for (int i = 0; i < exp_done.size(); i++) begin
            total++;
            if (done_base + i >= obs_done.size() || obs_done[done_base + i] != exp_done[i]) begin
                bad++; $display("FAIL clear_done[%0d] required cyc=%0d", i, exp_done[i]);
            end
        end
        total++;
        if (obs_done.size() - done_base != exp_done.size()) begin
            bad++; $display("FAIL clear_done_count got %0d required %0d", obs_done.size() - done_base, exp_done.size());
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    task automatic test_empty;
        int t;
        send(2'd0, 6'd0, 6'd50, 7'd4, 6'd2, 4'd3, 1'b0, t);
        settle(20);
        send(2'd0, 6'd3, 6'd3, 7'd0, 6'd5, 4'd3, 1'b0, t);
        settle(20);
        send(2'd3, 6'd1, 6'd1, 7'd5, 6'd5, 4'd3, 1'b0, t);
        settle(20);
        total++;
        if (obs_wr.size() - wr_base != exp_wr.size()) begin
            bad++; $display("FAIL empty_wr_count got %0d required %0d", obs_wr.size() - wr_base, exp_wr.size());
        end
        for (int i = 0; i < exp_done.size(); i++) begin
            total++;
            if (done_base + i >= obs_done.size() || obs_done[done_base + i] != exp_done[i]) begin
                bad++; $display("FAIL empty_done[%0d] required cyc=%0d", i, exp_done[i]);
            end
        end
        total++;
        if (obs_done.size() - done_base != exp_done.size()) begin
            bad++; $display("FAIL empty_done_count got %0d required %0d", obs_done.size() - done_base, exp_done.size());
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        send(2'd2, 6'd1, 6'd0, 7'd0, 6'd0, 4'd2, 1'b1, t1);
        send(2'd2, 6'd2, 6'd0, 7'd0, 6'd0, 4'd3, 1'b0, t2);
        total++;
        if (t2 != t1 + 3) begin
            bad++; $display("FAIL b2b_accept_gap got %0d required 3", t2 - t1);
        end
        settle(20);
        for (int i = 0; i < exp_wr.size(); i++) begin
            total++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL b2b_wr[%0d] got %h required cyc=%0d addr=%0d data=%0d", i,
                         (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : '0, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (obs_wr.size() - wr_base != exp_wr.size()) begin
            bad++; $display("FAIL b2b_wr_count got %0d required %0d", obs_wr.size() - wr_base, exp_wr.size());
        end
        for (int i = 0; i < exp_done.size(); i++) begin
            total++;
            if (done_base + i >= obs_done.size() || obs_done[done_base + i] != exp_done[i]) begin
                bad++; $display("FAIL b2b_done[%0d] required cyc=%0d", i, exp_done[i]);
            end
        end
        total++;
        if (obs_done.size() - done_base != exp_done.size()) begin
            bad++; $display("FAIL b2b_done_count got %0d required %0d", obs_done.size() - done_base, exp_done.size());
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    task automatic test_reset_mid_fill;
        int t;
        send(2'd1, 6'd0, 6'd0, 7'd0, 6'd0, 4'd5, 1'b0, t);
        while (exp_wr.size() > 10) void'(exp_wr.pop_back());
        exp_done.delete();
        while (cyc < t + 9) @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            total++;
            if ({oCMD_READY, oWREN, oBUSY, oDONE} !== 4'b1000) begin
                bad++;
                $display("FAIL rst_mid_idle[%0d] got rdy=%b wren=%b busy=%b done=%b, required 1 0 0 0",
                         i, oCMD_READY, oWREN, oBUSY, oDONE);
            end
            @(negedge iCLK);
        end
        for (int i = 0; i < exp_wr.size(); i++) begin
            total++;
            if (wr_base + i >= obs_wr.size() || obs_wr[wr_base + i] !== exp_wr[i]) begin
                bad++;
                $display("FAIL rst_mid_wr[%0d] got %h required cyc=%0d addr=%0d data=%0d", i,
                         (wr_base + i < obs_wr.size()) ? obs_wr[wr_base + i] : '0, exp_wr[i].c, exp_wr[i].a, exp_wr[i].d);
            end
        end
        total++;
        if (obs_wr.size() - wr_base != 10) begin
            bad++; $display("FAIL rst_mid_wr_count got %0d required 10", obs_wr.size() - wr_base);
        end
        total++;
        if (obs_done.size() - done_base != 0) begin
            bad++; $display("FAIL rst_mid_done_count got %0d required 0", obs_done.size() - done_base);
        end
        wr_base = obs_wr.size(); done_base = obs_done.size();
        exp_wr.delete(); exp_done.delete();
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        test_reset;
        test_single;
        test_clipped_rect;
        test_clear_all;
        test_empty;
        test_back_to_back;
        test_reset_mid_fill;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grid_cell_writer.md
# grid_cell_writer

Write-side engine for the 64x48 grid RAM that the VGA display path reads. Accepts drawing commands (single cell, clipped rectangle fill, full clear) over a valid/ready handshake. Expands each command into one RAM write per clock on the RAM's write port (`wraddress`/`data`/`wren`). Address layout matches the display reader: `addr = row*64 + col`, with 4-bit color indices.

## Interface
- `COLS`, 64, grid columns (fixed addressing stride)
- `ROWS`, 48, grid rows
- `AW`, 12, write address width
- `DW`, 4, color index width
- `iCLK`  in  1  single clock for the block and the RAM write port
- `iRST`  in  1  reset, synchronous, active-high
- `iCMD_VALID`  in  1  command present
- `oCMD_READY`  out  1  block can accept a command
- `iCMD_OP`  in  2  opcode: 0 = rect fill, 1 = clear all, 2 = single cell, 3 = no-op
- `iX`  in  6  start column, 0..63
- `iY`  in  6  start row; values 48..63 are off-grid
- `iW`  in  7  rect width in cells
- `iH`  in  6  rect height in cells
- `iCOLOR`  in  DW  color index to write
- `oWRADDR`  out  AW  RAM write address
- `oWRDATA`  out  DW  RAM write data
- `oWREN`  out  1  RAM write enable
- `oBUSY`  out  1  command in progress (state FILL or DONE)
- `oDONE`  out  1  one-cycle pulse when a command completes

## Operation
- **FSM states:**
  - IDLE: `oCMD_READY=1`.
  - FILL: one write per cycle.
  - DONE: `oDONE=1` for one cycle, then IDLE.
- **Accept:** a command is accepted on a rising edge where `iCMD_VALID && oCMD_READY`. Operands are latched on that edge. Inputs are ignored at all other times.
- **Opcode normalisation at accept:**
  - op 2 → rect with w=1, h=1.
  - op 1 → x=0, y=0, w=64, h=48 (iX/iY/iW/iH ignored).
  - op 3 → empty.
- **Clipping:**
  - Column end (exclusive) is `xe = min(x+w, 64)`, computed at 7 bits.
  - Row end (exclusive) is `ye = min(y+h, 48)`, computed at 7 bits.
  - The command is empty if w==0, h==0, or y≥48.
  - An empty command goes straight IDLE→DONE with no writes.
- **Scan order:** row-major. Column cx runs x..xe-1; at xe-1, cx returns to x and cy increments. The write where cx==xe-1 and cy==ye-1 is the last one; the next state after it is DONE.
- **Address:** `oWRADDR = {cy[5:0], cx[5:0]}`, which equals cy*64+cx. `oWRDATA` = latched color.
- **Registered outputs:** all outputs are registered. `oWREN=1` only in FILL; `oWRADDR`/`oWRDATA` hold their last values when `oWREN=0`.
- `oBUSY = !oCMD_READY`.
- **Reset values:** state IDLE, `oCMD_READY=1`, `oWREN=0`, `oWRADDR=0`, `oWRDATA=0`, `oBUSY=0`, `oDONE=0`.
- **Reset mid-command:** the command is abandoned with no further writes and no `oDONE`. Cells already written stay written.

## Timing
- Accept edge = T.
- For a non-empty command with N = (xe-x)*(ye-y) writes:
  - writes are on cycles T+1..T+N;
  - `oDONE` is high at T+N+1;
  - `oCMD_READY` is high again at T+N+2.
- Empty command: `oDONE` at T+1, ready at T+2.
- Clear all: N=3072, so `oDONE` at T+3073.
- Throughput is one cell per clock. There are no bubbles inside a command and exactly one DONE cycle between commands.
- **Held valid:** if `iCMD_VALID` stays high through DONE, the next accept occurs at T+N+2. No command is dropped or double-accepted.
- **Reset timing:** `iRST` sampled high at an edge forces reset values at that edge. `oWREN` is 0 from that edge on.
- `oWRADDR`/`oWRDATA`/`oWREN` change only on `iCLK` rising edges. They are stable for the RAM's registered write port.

## Test plan
- Single cell: op=2, x=5, y=3, color=9 → one write at T+1 with addr 197, data 9; `oDONE` at T+2; ready at T+3.
- Clipped rect: op=0, x=62, y=46, w=4, h=4, color=7 → writes addr 3006, 3007, 3070, 3071 on T+1..T+4, data 7; `oDONE` at T+5.
- Clear all: op=1, color=0 → 3072 consecutive writes, addr 0..3071 in order, no gaps; `oDONE` at T+3073.
- Empty commands: op=0 with y=50; op=0 with w=0; op=3 → `oWREN` never asserts; `oDONE` at T+1 for each.
- Back-to-back: op=2 (x=1, y=0, c=2) then op=2 (x=2, y=0, c=3), with valid held high throughout → second accept at T+3; writes addr 1 at T+1 and addr 2 at T+4.
- Reset mid-fill: start clear all, assert `iRST` for one cycle after the 10th write → exactly 10 writes (addr 0..9), `oWREN=0` from the reset edge, no `oDONE`, `oCMD_READY=1` from the reset edge on.
